// File: rtl/vco_clk_divider_if.sv
// rtl/vco_clk_divider_if.sv - ratio request handshake between requester and divider
interface vco_clk_divider_if #(
  parameter int DIV_WIDTH = 8
);
  logic [DIV_WIDTH-1:0] div_i;
  logic                 div_valid_i;
  logic                 div_ready_o;

  modport master (
    output div_i,
    output div_valid_i,
    input  div_ready_o
  );

  modport slave (
    input  div_i,
    input  div_valid_i,
    output div_ready_o
  );
endinterface

// File: rtl/vco_clk_divider.sv
// rtl/vco_clk_divider.sv - glitch-free programmable integer divider on the VCO clock
module vco_clk_divider #(
  parameter int DIV_WIDTH = 8,
  parameter int RESET_DIV = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  vco_clk_divider_if.slave     req,
  output logic [DIV_WIDTH-1:0] active_div_o,
  output logic                 clk_o,
  output logic                 tick_o
);

  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  // ST_IDLE is the single cycle after reset, before period k=0 starts.
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] active, active_n;
  logic [DIV_WIDTH-1:0] pend_div, pend_div_n;
  logic                 pend_v, pend_v_n;
  logic                 ready, ready_n;
  logic                 clk_n, tick_n;
  logic                 boundary;
  logic                 xfer;

  // Next-state: counter advance, ratio application at period end, handshake and output decode.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    active_n   = active;
    pend_div_n = pend_div;
    pend_v_n   = pend_v;
    ready_n    = ready;
    clk_n      = 1'b0;
    tick_n     = 1'b0;

    xfer     = req.div_valid_i & ready;
    // Ratios 0 and 1 make every cycle a boundary; otherwise the last cycle k=N-1.
    boundary = (active <= ONE) || (cnt == active - ONE);

    case (state)
      ST_IDLE: begin
        state_n = ST_RUN;
        cnt_n   = '0;
      end
      default: begin
        if (boundary) begin
          cnt_n = '0;
          // Only a ratio already pending before this cycle is applied; no same-cycle bypass.
          if (pend_v) begin
            active_n = pend_div;
            pend_v_n = 1'b0;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end
    endcase

    // Ready reopens one cycle after the pending ratio has taken effect.
    if (xfer) begin
      pend_v_n   = 1'b1;
      pend_div_n = req.div_i;
      ready_n    = 1'b0;
    end else if (!pend_v) begin
      ready_n = 1'b1;
    end

    // Outputs are decoded from the next k so the registered values line up with it.
    if (state_n == ST_RUN) begin
      tick_n = (active_n != '0) && (cnt_n == '0);
      clk_n  = (active_n == ONE) || (cnt_n < (active_n >> 1));
    end
  end

  // State and output registers; reset discards any pending ratio.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      active   <= RST_DIV;
      pend_div <= '0;
      pend_v   <= 1'b0;
      ready    <= 1'b1;
      clk_o    <= 1'b0;
      tick_o   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      active   <= active_n;
      pend_div <= pend_div_n;
      pend_v   <= pend_v_n;
      ready    <= ready_n;
      clk_o    <= clk_n;
      tick_o   <= tick_n;
    end
  end

  assign req.div_ready_o = ready;
  assign active_div_o    = active;

endmodule

// File: tb/tb_vco_clk_divider.sv
// tb/tb_vco_clk_divider.sv - scoreboard bench for vco_clk_divider
module tb_vco_clk_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] active_div;
  logic         clk_div;
  logic         tick;

  vco_clk_divider_if #(.DIV_WIDTH(W)) bus ();

  vco_clk_divider #(
    .DIV_WIDTH(W),
    .RESET_DIV(2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req          (bus.slave),
    .active_div_o (active_div),
    .clk_o        (clk_div),
    .tick_o       (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         c;
    logic         t;
    logic         r;
    logic [W-1:0] a;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  function automatic exp_t mk(input int n, input int k, input logic rdy);
    exp_t e;
    e.r = rdy;
    e.a = W'(n);
    if (n == 0)      begin e.c = 1'b0; e.t = 1'b0; end
    else if (n == 1) begin e.c = 1'b1; e.t = 1'b1; end
    else             begin e.c = (k < n / 2); e.t = (k == 0); end
    return e;
  endfunction

  function automatic exp_t mk_rst();
    exp_t e;
    e.c = 1'b0;
    e.t = 1'b0;
    e.r = 1'b1;
    e.a = W'(2);
    return e;
  endfunction

  // One clock cycle: compare outputs mid-cycle, then move past the next edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check("clk_o",        int'(clk_div),        int'(e.c));
      check("tick_o",       int'(tick),           int'(e.t));
      check("div_ready_o",  int'(bus.div_ready_o), int'(e.r));
      check("active_div_o", int'(active_div),     int'(e.a));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n, input int k0, input int k1, input logic rdy);
    for (int k = k0; k <= k1; k++) sb.push_back(mk(n, k, rdy));
    for (int k = k0; k <= k1; k++) step();
  endtask

  task automatic run_rst();
    sb.push_back(mk_rst());
    step();
  endtask

  task automatic request(input int n);
    bus.div_i       = W'(n);
    bus.div_valid_i = 1'b1;
  endtask

  task automatic drop();
    bus.div_valid_i = 1'b0;
  endtask

  initial begin
    bus.div_i       = '0;
    bus.div_valid_i = 1'b0;
    rst             = 1'b1;
    @(posedge clk);
    #1;
    run_rst();
    rst = 1'b0;
    run_rst();

    // Default ratio 2 after reset
    for (int p = 0; p < 3; p++) run(2, 0, 1, 1'b1);

    // Request 5 at k=0 of an N=2 period
    request(5);
    run(2, 0, 0, 1'b1);
    drop();
    run(2, 1, 1, 1'b0);
    run(5, 0, 0, 1'b0);
    run(5, 1, 4, 1'b1);
    run(5, 0, 4, 1'b1);

    // Request 7 on the last cycle of an N=5 period; 3 is held while ready is low
    run(5, 0, 3, 1'b1);
    request(7);
    run(5, 4, 4, 1'b1);
    request(3);
    run(5, 0, 4, 1'b0);
    run(7, 0, 0, 1'b0);
    run(7, 1, 1, 1'b1);
    drop();
    run(7, 2, 6, 1'b0);
    run(3, 0, 0, 1'b0);
    run(3, 1, 2, 1'b1);
    run(3, 0, 2, 1'b1);

    // Disable, then request 4 while disabled
    request(0);
    run(3, 0, 0, 1'b1);
    drop();
    run(3, 1, 2, 1'b0);
    run(0, 0, 0, 1'b0);
    run(0, 0, 3, 1'b1);
    request(4);
    run(0, 0, 0, 1'b1);
    drop();
    run(0, 0, 0, 1'b0);
    run(4, 0, 0, 1'b0);
    run(4, 1, 3, 1'b1);
    run(4, 0, 3, 1'b1);

    // Ratio 1, then maximum ratio 255
    request(1);
    run(4, 0, 0, 1'b1);
    drop();
    run(4, 1, 3, 1'b0);
    run(1, 0, 0, 1'b0);
    run(1, 0, 3, 1'b1);
    request(255);
    run(1, 0, 0, 1'b1);
    drop();
    run(1, 0, 0, 1'b0);
    run(255, 0, 0, 1'b0);
    run(255, 1, 254, 1'b1);
    run(255, 0, 254, 1'b1);

    // Move to N=6, then reset at k=3 with a ratio of 9 pending
    request(6);
    run(255, 0, 0, 1'b1);
    drop();
    run(255, 1, 254, 1'b0);
    run(6, 0, 0, 1'b0);
    run(6, 1, 5, 1'b1);
    run(6, 0, 1, 1'b1);
    request(9);
    run(6, 2, 2, 1'b1);
    drop();
    rst = 1'b1;
    run(6, 3, 3, 1'b0);
    rst = 1'b0;
    run_rst();
    for (int p = 0; p < 8; p++) run(2, 0, 1, 1'b1);

    check("sb_leftover", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
